cond_unit: RTL and testbench
============================

# cond_unit

Conditional-execution unit for the single-cycle ARM datapath: it consumes the NZCV flags produced by the ALU flag generator, holds them in the architectural flag register, evaluates each instruction's 4-bit condition field against the stored flags, and gates the decoder's write and branch strobes. It sits between the main decoder/ALU and the register file, data memory and PC-select mux.

## Interface
- Parameters:
- CNT_W, 16, width of the executed/squashed instruction counters (statistics build only)
- Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  current instruction is real; 0 = bubble/fetch stall
- cond  in  4  instruction condition field, bits [31:28]
- alu_flags  in  4  ALU flags {N,Z,C,V} from the flag generator
- flag_w  in  2  flag write request: [1] writes N,Z; [0] writes C,V
- pcs  in  1  decoder request to redirect the PC
- reg_w  in  1  decoder request to write the register file
- mem_w  in  1  decoder request to write data memory
- no_write  in  1  compare-class instruction; suppress reg_write
- cond_ex  out  1  condition passed and instruction valid
- pc_src  out  1  pcs & cond_ex
- reg_write  out  1  reg_w & cond_ex & ~no_write
- mem_write  out  1  mem_w & cond_ex
- flags  out  4  current flag register {N,Z,C,V}
- exec_count  out  CNT_W  executed-instruction counter (COND_STATS_EN only)
- squash_count  out  CNT_W  squashed-instruction counter (COND_STATS_EN only)

## Operation
- Flag register: two independent 2-bit fields, NZ = flags[3:2] and CV = flags[1:0].
- Field update at a rising edge: NZ <= alu_flags[3:2] when flag_w[1] & cond_ex; CV <= alu_flags[1:0] when flag_w[0] & cond_ex. Otherwise each field holds.
- Condition is evaluated against the *registered* flags, never alu_flags, so an instruction's own flag result cannot affect its own condition.
- Condition encoding (pass = 1):
  - 0000 EQ: Z. 0001 NE: ~Z. 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N. 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z. 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V). 1110 AL: 1.
  - 1111: 0 (treated as never; the instruction is squashed).
- cond_ex = pass & instr_valid & rst_n. When instr_valid=0, no flag write, no strobe and no count occurs.
- A squashed instruction (valid, condition failed) drives all strobes to 0 and leaves both flag fields unchanged, even if flag_w is nonzero.

## Timing
- cond_ex, pc_src, reg_write and mem_write are combinational from cond, the strobes and the registered flags (zero-cycle latency).
- Flag updates are visible on flags and to the condition logic one cycle after the writing instruction.
- Reset (rst_n=0, asynchronous): flags=4'b0000 and counters=0 immediately. All gated outputs are forced to 0 while rst_n is low. If reset asserts mid-cycle, a flag write pending for that cycle is lost.
- First edge after reset release: the condition is evaluated against flags=0000. EQ fails, NE passes.
- Simultaneous flag_w[1] and flag_w[0] on a passing instruction update all four bits in the same edge.

## Configuration
- COND_STATS_EN defined: two CNT_W-bit counters are built.
  - exec_count increments on each edge where cond_ex=1.
  - squash_count increments on each edge where instr_valid=1 and the condition fails.
  - Both counters saturate at all-ones and never wrap. Both reset to 0.
- COND_STATS_EN undefined: counters are not built, and exec_count and squash_count are tied to 0. All other behaviour is identical.

## Test plan
- Reset with cond=0000, instr_valid=1 -> flags=0000, cond_ex=0. Then cond=0001 -> cond_ex=1.
- cond=1110, flag_w=11, alu_flags=0110 -> after the edge flags=0110. Next cycle cond=0000 (EQ) with reg_w=1 -> reg_write=1.
- flags=0110, cond=0001 (NE), flag_w=11, alu_flags=1000 -> instruction squashed: all strobes 0, flags stay 0110, squash_count +1.
- Partial write: flags=0000, cond=1110, flag_w=10, alu_flags=1111 -> flags=1100. Then flag_w=01, alu_flags=0011 -> flags=1111.
- Signed checks with flags N=1,V=0: GE -> 0, LT -> 1, GT -> 0, LE -> 1. With cond=1110, no_write=1, reg_w=1 -> reg_write=0 and cond_ex=1.
- COND_STATS_EN build, CNT_W=2: five consecutive AL instructions -> exec_count holds at 3. Assert rst_n=0 mid-run -> counters and flags return to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, condition evaluation, strobe gating; COND_STATS_EN adds executed/squashed counters.
// Gated strobes are combinational (zero latency); flag and counter updates land on the next rising edge; no backpressure.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    output logic             cond_ex,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] squash_count
);

    logic [1:0] r_nz;
    logic [1:0] r_cv;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_pass;

    assign {w_n, w_z} = r_nz;
    assign {w_c, w_v} = r_cv;

    // Evaluated against the registered flags so an instruction never sees its own result.
    always_comb begin
        w_pass = 1'b0;
        case (cond)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign cond_ex   = w_pass & instr_valid & rst_n;
    assign pc_src    = pcs & cond_ex;
    assign reg_write = reg_w & cond_ex & ~no_write;
    assign mem_write = mem_w & cond_ex;
    assign flags     = {r_nz, r_cv};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz <= 2'b00;
            r_cv <= 2'b00;
        end else begin
            if (flag_w[1] && cond_ex) r_nz <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) r_cv <= alu_flags[1:0];
        end
    end

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] r_exec;
    logic [CNT_W-1:0] r_squash;
    logic             w_squash;

    assign w_squash = instr_valid & ~w_pass & rst_n;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exec   <= '0;
            r_squash <= '0;
        end else begin
            if (cond_ex && (r_exec != {CNT_W{1'b1}}))
                r_exec <= r_exec + CNT_W'(1);
            if (w_squash && (r_squash != {CNT_W{1'b1}}))
                r_squash <= r_squash + CNT_W'(1);
        end
    end

    assign exec_count   = r_exec;
    assign squash_count = r_squash;
`else
    assign exec_count   = '0;
    assign squash_count = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit with a behavioural flag/condition model.
module tb_cond_unit;

    localparam int TB_CNT_W = 2;
    localparam int MAXC     = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                instr_valid = 1'b0;
    logic [3:0]          cond = 4'd0;
    logic [3:0]          alu_flags = 4'd0;
    logic [1:0]          flag_w = 2'd0;
    logic                pcs = 1'b0;
    logic                reg_w = 1'b0;
    logic                mem_w = 1'b0;
    logic                no_write = 1'b0;
    logic                cond_ex;
    logic                pc_src;
    logic                reg_write;
    logic                mem_write;
    logic [3:0]          flags;
    logic [TB_CNT_W-1:0] exec_count;
    logic [TB_CNT_W-1:0] squash_count;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;
    int   m_exec = 0;
    int   m_squash = 0;

    cond_unit #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .cond(cond),
        .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w),
        .mem_w(mem_w), .no_write(no_write), .cond_ex(cond_ex), .pc_src(pc_src),
        .reg_write(reg_write), .mem_write(mem_write), .flags(flags),
        .exec_count(exec_count), .squash_count(squash_count)
    );

    always #5 clk = ~clk;

    function automatic logic ref_pass(input logic [3:0] c);
        logic signed_ge;
        signed_ge = (m_n == m_v);
        case (c)
            4'd0:  return m_z;
            4'd1:  return !m_z;
            4'd2:  return m_c;
            4'd3:  return !m_c;
            4'd4:  return m_n;
            4'd5:  return !m_n;
            4'd6:  return m_v;
            4'd7:  return !m_v;
            4'd8:  return m_c && !m_z;
            4'd9:  return !m_c || m_z;
            4'd10: return signed_ge;
            4'd11: return !signed_ge;
            4'd12: return !m_z && signed_ge;
            4'd13: return m_z || !signed_ge;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [3:0] c, input logic [3:0] af,
                          input logic [1:0] fw, input logic p, input logic rw,
                          input logic mw, input logic nw);
        instr_valid = v; cond = c; alu_flags = af; flag_w = fw;
        pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    endtask

    task automatic model_reset();
        m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_exec = 0; m_squash = 0;
    endtask

    // Advance one rising edge, updating the model from the inputs seen there.
    task automatic tick();
        logic ce, ok;
        @(posedge clk);
        ok = ref_pass(cond);
        ce = ok && instr_valid && rst_n;
        if (ce && flag_w[1]) {m_n, m_z} = alu_flags[3:2];
        if (ce && flag_w[0]) {m_c, m_v} = alu_flags[1:0];
`ifdef COND_STATS_EN
        if (ce && m_exec < MAXC) m_exec++;
        if (rst_n && instr_valid && !ok && m_squash < MAXC) m_squash++;
`endif
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        set_in(1, 4'b0000, 4'hF, 2'b11, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        checks++; if ({cond_ex, pc_src, reg_write, mem_write} !== 4'b0000) begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {cond_ex, pc_src, reg_write, mem_write}); end
        checks++; if (exec_count !== '0 || squash_count !== '0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", exec_count, squash_count); end
        tick();
        #2 rst_n = 1'b1;
        set_in(1, 4'b0000, 4'h0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL post_reset_eq got=%b exp=0", cond_ex); end
        tick();
        set_in(1, 4'b0001, 4'h0, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL post_reset_ne got=%b exp=1", cond_ex); end
        tick();
    endtask

    task automatic test_flag_update();
        set_in(1, 4'b1110, 4'b0110, 2'b11, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL al_cond_ex got=%b exp=1", cond_ex); end
        tick();
        set_in(1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL flag_write_all got=%b exp=0110", flags); end
        checks++; if (reg_write !== 1'b1) begin failures++; $display("FAIL eq_reg_write got=%b exp=1", reg_write); end
        tick();
        // Failing NE must squash strobes and block the flag write.
        set_in(1, 4'b0001, 4'b1000, 2'b11, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if ({cond_ex, pc_src, reg_write, mem_write} !== 4'b0000) begin failures++; $display("FAIL squash_strobes got=%b exp=0000", {cond_ex, pc_src, reg_write, mem_write}); end
        tick();
        set_in(0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL squash_flags got=%b exp=0110", flags); end
        checks++; if (squash_count !== TB_CNT_W'(m_squash)) begin failures++; $display("FAIL squash_count got=%0d exp=%0d", squash_count, m_squash); end
        checks++; if ({cond_ex, pc_src, reg_write, mem_write} !== 4'b0000) begin failures++; $display("FAIL bubble_strobes got=%b exp=0000", {cond_ex, pc_src, reg_write, mem_write}); end
        tick();
        set_in(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL bubble_flags got=%b exp=0110", flags); end
        tick();
    endtask

    task automatic test_partial_write();
        set_in(1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0); tick();
        set_in(1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0); tick();
        set_in(1, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b1100) begin failures++; $display("FAIL partial_nz got=%b exp=1100", flags); end
        tick();
        set_in(1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (flags !== 4'b1111) begin failures++; $display("FAIL partial_cv got=%b exp=1111", flags); end
        tick();
    endtask

    task automatic test_signed();
        logic [3:0] cs [4];
        logic       ex [4];
        cs = '{4'b1010, 4'b1011, 4'b1100, 4'b1101};
        ex = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_in(1, 4'b1110, 4'b1000, 2'b11, 0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, cs[i], 4'b0000, 2'b00, 0, 0, 0, 0);
            @(negedge clk);
            checks++; if (cond_ex !== ex[i]) begin failures++; $display("FAIL signed_cond%b got=%b exp=%b", cs[i], cond_ex, ex[i]); end
            tick();
        end
        set_in(1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 1);
        @(negedge clk);
        checks++; if (reg_write !== 1'b0 || cond_ex !== 1'b1) begin failures++; $display("FAIL no_write got=%b/%b exp=0/1", reg_write, cond_ex); end
        tick();
    endtask

    task automatic test_random();
        logic ce;
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            @(negedge clk);
            ce = ref_pass(cond) && instr_valid;
            checks++; if (cond_ex !== ce) begin failures++; $display("FAIL rnd_cond_ex i=%0d cond=%b got=%b exp=%b", i, cond, cond_ex, ce); end
            checks++; if (pc_src !== (ce && pcs)) begin failures++; $display("FAIL rnd_pc_src i=%0d got=%b exp=%b", i, pc_src, ce && pcs); end
            checks++; if (reg_write !== (ce && reg_w && !no_write)) begin failures++; $display("FAIL rnd_reg_write i=%0d got=%b exp=%b", i, reg_write, ce && reg_w && !no_write); end
            checks++; if (mem_write !== (ce && mem_w)) begin failures++; $display("FAIL rnd_mem_write i=%0d got=%b exp=%b", i, mem_write, ce && mem_w); end
            checks++; if (flags !== {m_n, m_z, m_c, m_v}) begin failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, flags, {m_n, m_z, m_c, m_v}); end
            checks++; if (exec_count !== TB_CNT_W'(m_exec) || squash_count !== TB_CNT_W'(m_squash)) begin failures++; $display("FAIL rnd_counts i=%0d got=%0d/%0d exp=%0d/%0d", i, exec_count, squash_count, m_exec, m_squash); end
            tick();
        end
    endtask

    task automatic test_saturate_and_async_reset();
        int exp_sat;
`ifdef COND_STATS_EN
        exp_sat = MAXC;
`else
        exp_sat = 0;
`endif
        rst_n = 1'b0; model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
            tick();
        end
        set_in(1, 4'b1110, 4'b0101, 2'b11, 1, 1, 1, 0);
        @(negedge clk);
        checks++; if (exec_count !== TB_CNT_W'(exp_sat)) begin failures++; $display("FAIL exec_saturate got=%0d exp=%0d", exec_count, exp_sat); end
        checks++; if (flags !== 4'b1111) begin failures++; $display("FAIL pre_reset_flags got=%b exp=1111", flags); end
        #1 rst_n = 1'b0; model_reset();
        #1;
        checks++; if (flags !== 4'b0000 || exec_count !== '0 || squash_count !== '0) begin failures++; $display("FAIL async_reset got=%b/%0d/%0d exp=0000/0/0", flags, exec_count, squash_count); end
        checks++; if ({cond_ex, pc_src, reg_write, mem_write} !== 4'b0000) begin failures++; $display("FAIL async_reset_strobes got=%b exp=0000", {cond_ex, pc_src, reg_write, mem_write}); end
        tick();
        checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL lost_write got=%b exp=0000", flags); end
        #2 rst_n = 1'b1;
        set_in(1, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL rerelease_ne got=%b exp=1", cond_ex); end
        tick();
    endtask

    initial begin
        test_reset();
        test_flag_update();
        test_partial_write();
        test_signed();
        test_random();
        test_saturate_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
